// File: rtl/spmv_mem_responder_if.sv
// ---------------------------------------------------------------------------
// spmv_mem_responder_if
// Request/response bundle between an SpMV processing element (master) and
// its memory-side responder (slave).
//   req_mem_ld / req_mem_st   : load / store request strobes (PE -> mem)
//   req_mem_addr              : 48-bit byte address (PE -> mem)
//   req_mem_d_or_tag          : store data, or load tag in [2:0] (PE -> mem)
//   req_mem_stall             : advisory "stop issuing" (mem -> PE)
//   rsp_mem_push/tag/q        : one-cycle load response (mem -> PE)
//   rsp_mem_stall             : consumer not ready this cycle (PE -> mem)
// ---------------------------------------------------------------------------
interface spmv_mem_responder_if;
    logic        req_mem_ld;
    logic        req_mem_st;
    logic [47:0] req_mem_addr;
    logic [63:0] req_mem_d_or_tag;
    logic        req_mem_stall;
    logic        rsp_mem_push;
    logic [2:0]  rsp_mem_tag;
    logic [63:0] rsp_mem_q;
    logic        rsp_mem_stall;

    modport master (
        output req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag, rsp_mem_stall,
        input  req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q
    );

    modport slave (
        input  req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag, rsp_mem_stall,
        output req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q
    );
endinterface

// File: rtl/spmv_mem_responder.sv
// ---------------------------------------------------------------------------
// spmv_mem_responder
// Memory-side responder for the SpMV PE memory port. Loads and stores are
// serviced from a local word-addressed SRAM; load results travel through a
// (LATENCY-1)-stage valid pipeline into a response FIFO and are returned in
// acceptance order. A host port preloads and reads back the SRAM.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   mem (slave)         : PE request/response bundle
//   host_we/addr/d      : host write port (word index)
//   host_q              : registered host read data (write-first)
//   overflow            : sticky, a load was dropped at a full FIFO
//   conflict            : sticky, ld and st were asserted together
// Parameters: LATENCY >= 2, FIFO_DEPTH >= LATENCY+8, ADDR_BITS <= 44.
// ---------------------------------------------------------------------------
module spmv_mem_responder #(
    parameter int ADDR_BITS    = 10,
    parameter int LATENCY      = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int STALL_MARGIN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spmv_mem_responder_if.slave  mem,
    input  logic                 host_we,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic [63:0]          host_d,
    output logic [63:0]          host_q,
    output logic                 overflow,
    output logic                 conflict
);
    localparam int DEPTH  = 1 << ADDR_BITS;
    localparam int STAGES = LATENCY - 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W  = $clog2(FIFO_DEPTH + STAGES + 1);

    localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [OUT_W-1:0] STALL_LEVEL = OUT_W'(FIFO_DEPTH - STALL_MARGIN);

    // ---------------- request decode ----------------
    logic [ADDR_BITS-1:0] pe_idx;
    logic                 pe_ld;
    logic                 pe_st;
    logic                 unused_addr_bits;

    assign pe_idx = mem.req_mem_addr[ADDR_BITS+2:3];
    assign pe_st  = mem.req_mem_st;
    // A load paired with a store is discarded; the store still executes.
    assign pe_ld  = mem.req_mem_ld & ~mem.req_mem_st;
    assign unused_addr_bits = ^{mem.req_mem_addr[47:ADDR_BITS+3], mem.req_mem_addr[2:0]};

    // ---------------- SRAM (contents survive reset) ----------------
    logic [63:0] sram [DEPTH];

    always_ff @(posedge clk) begin
        // PE store wins over a host write to the same word.
        if (host_we && !(pe_st && (pe_idx == host_addr))) begin
            sram[host_addr] <= host_d;
        end
        if (pe_st) begin
            sram[pe_idx] <= mem.req_mem_d_or_tag;
        end
    end

    // ---------------- load pipeline ----------------
    // Stage 0 data is the registered SRAM read itself.
    logic [STAGES-1:0] vld_q, vld_d;
    logic [2:0]        tag_q [STAGES];
    logic [2:0]        tag_d [STAGES];
    logic [63:0]       dat_q [STAGES];
    logic [63:0]       dat_d [STAGES];

    assign vld_d[0] = pe_ld;
    assign tag_d[0] = mem.req_mem_d_or_tag[2:0];
    assign dat_d[0] = sram[pe_idx];

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
            assign vld_d[gi] = vld_q[gi-1];
            assign tag_d[gi] = tag_q[gi-1];
            assign dat_d[gi] = dat_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            tag_q[i] <= tag_d[i];
            dat_q[i] <= dat_d[i];
        end
    end

    // ---------------- response FIFO ----------------
    logic [2:0]       fifo_tag [FIFO_DEPTH];
    logic [63:0]      fifo_dat [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             exit_vld;
    logic             fifo_wr;
    logic             fifo_pop;
    logic             drop;

    always_comb begin
        exit_vld = vld_q[STAGES-1];
        fifo_pop = (count_q != '0) && !mem.rsp_mem_stall;
        // A full FIFO still takes the entry when the head leaves this cycle.
        fifo_wr  = exit_vld && ((count_q != CNT_FULL) || fifo_pop);
        drop     = exit_vld && !fifo_wr;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_wr) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end
        if (fifo_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
        end
        case ({fifo_wr, fifo_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_tag[wr_ptr_q] <= tag_q[STAGES-1];
            fifo_dat[wr_ptr_q] <= dat_q[STAGES-1];
        end
    end

    // ---------------- stall, sticky flags, host read ----------------
    logic [OUT_W-1:0] outstanding;
    logic             stall_q, stall_d;
    logic             overflow_q, overflow_d;
    logic             conflict_q, conflict_d;
    logic [63:0]      host_q_q, host_q_d;

    always_comb begin
        outstanding = OUT_W'(count_q);
        for (int i = 0; i < STAGES; i++) begin
            outstanding = outstanding + OUT_W'(vld_q[i]);
        end
        stall_d    = (outstanding >= STALL_LEVEL);
        overflow_d = overflow_q | drop;
        conflict_d = conflict_q | (mem.req_mem_ld & mem.req_mem_st);

        // Write-first: host_q shows the word as it will be after this edge.
        if (pe_st && (pe_idx == host_addr)) begin
            host_q_d = mem.req_mem_d_or_tag;
        end else if (host_we) begin
            host_q_d = host_d;
        end else begin
            host_q_d = sram[host_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
            conflict_q <= 1'b0;
            host_q_q   <= '0;
        end else begin
            vld_q      <= vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
            conflict_q <= conflict_d;
            host_q_q   <= host_q_d;
        end
    end

    // ---------------- outputs ----------------
    // Tag/data are forced to zero when not pushing so they never expose
    // stale or uninitialised FIFO contents.
    assign mem.req_mem_stall = stall_q;
    assign mem.rsp_mem_push  = fifo_pop;
    assign mem.rsp_mem_tag   = fifo_pop ? fifo_tag[rd_ptr_q] : 3'd0;
    assign mem.rsp_mem_q     = fifo_pop ? fifo_dat[rd_ptr_q] : 64'd0;
    assign host_q            = host_q_q;
    assign overflow          = overflow_q;
    assign conflict          = conflict_q;

endmodule

// File: tb/tb_spmv_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_spmv_mem_responder
// Directed bench for spmv_mem_responder. Inputs are driven on the falling
// edge; outputs are sampled 1 time unit later, i.e. inside the same cycle.
// ---------------------------------------------------------------------------
module tb_spmv_mem_responder;
    localparam int ADDR_BITS    = 10;
    localparam int LATENCY      = 4;
    localparam int FIFO_DEPTH   = 16;
    localparam int STALL_MARGIN = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 host_we;
    logic [ADDR_BITS-1:0] host_addr;
    logic [63:0]          host_d;
    logic [63:0]          host_q;
    logic                 overflow;
    logic                 conflict;

    int n_cmp = 0;
    int n_bad = 0;

    spmv_mem_responder_if mem_if ();

    spmv_mem_responder #(
        .ADDR_BITS   (ADDR_BITS),
        .LATENCY     (LATENCY),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .STALL_MARGIN(STALL_MARGIN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem      (mem_if),
        .host_we  (host_we),
        .host_addr(host_addr),
        .host_d   (host_d),
        .host_q   (host_q),
        .overflow (overflow),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    // Data preloaded into word 100+i.
    function automatic logic [63:0] dval(input int i);
        return {32'hA5A5_5A5A, 32'(i) * 32'h0001_0003};
    endfunction

    task automatic idle();
        mem_if.req_mem_ld       = 1'b0;
        mem_if.req_mem_st       = 1'b0;
        mem_if.req_mem_addr     = '0;
        mem_if.req_mem_d_or_tag = '0;
        host_we                 = 1'b0;
    endtask

    task automatic drive_load(input int word, input int tag);
        mem_if.req_mem_ld       = 1'b1;
        mem_if.req_mem_st       = 1'b0;
        mem_if.req_mem_addr     = 48'(word * 8);
        mem_if.req_mem_d_or_tag = 64'(tag);
    endtask

    task automatic preload_words();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            idle();
            host_we   = 1'b1;
            host_addr = ADDR_BITS'(100 + i);
            host_d    = dval(i);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        idle();
        mem_if.rsp_mem_stall = 1'b0;
        host_addr = '0;
        host_d    = '0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (mem_if.rsp_mem_push !== 1'b0) begin n_bad++; $display("FAIL reset_push: got %b expected 0", mem_if.rsp_mem_push); end
        n_cmp++; if (mem_if.req_mem_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", mem_if.req_mem_stall); end
        n_cmp++; if (mem_if.rsp_mem_tag !== 3'd0) begin n_bad++; $display("FAIL reset_tag: got %0d expected 0", mem_if.rsp_mem_tag); end
        n_cmp++; if (mem_if.rsp_mem_q !== 64'd0) begin n_bad++; $display("FAIL reset_q: got %h expected 0", mem_if.rsp_mem_q); end
        n_cmp++; if (host_q !== 64'd0) begin n_bad++; $display("FAIL reset_host_q: got %h expected 0", host_q); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_cmp++; if (conflict !== 1'b0) begin n_bad++; $display("FAIL reset_conflict: got %b expected 0", conflict); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_host_preload();
        @(negedge clk);
        idle();
        host_we   = 1'b1;
        host_addr = 10'd5;
        host_d    = 64'h1122334455667788;
        @(negedge clk);
        idle();
        drive_load(5, 3);                       // byte address 0x28
        #1;
        n_cmp++; if (host_q !== 64'h1122334455667788) begin n_bad++; $display("FAIL preload_host_q: got %h expected 1122334455667788", host_q); end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            idle();
            #1;
            if (k == LATENCY) begin
                n_cmp++; if (mem_if.rsp_mem_push !== 1'b1) begin n_bad++; $display("FAIL preload_push: got %b expected 1", mem_if.rsp_mem_push); end
                n_cmp++; if (mem_if.rsp_mem_tag !== 3'd3) begin n_bad++; $display("FAIL preload_tag: got %0d expected 3", mem_if.rsp_mem_tag); end
                n_cmp++; if (mem_if.rsp_mem_q !== 64'h1122334455667788) begin n_bad++; $display("FAIL preload_data: got %h expected 1122334455667788", mem_if.rsp_mem_q); end
                $display("rsp tag=%0d q=%h", mem_if.rsp_mem_tag, mem_if.rsp_mem_q);
            end else begin
                n_cmp++; if (mem_if.rsp_mem_push !== 1'b0) begin n_bad++; $display("FAIL preload_idle_push k=%0d: got %b expected 0", k, mem_if.rsp_mem_push); end
            end
        end
    endtask

    task automatic test_store_load();
        @(negedge clk);
        idle();
        mem_if.req_mem_st       = 1'b1;
        mem_if.req_mem_addr     = 48'h38;       // word 7
        mem_if.req_mem_d_or_tag = 64'hDEAD;
        @(negedge clk);
        idle();
        drive_load(7, 1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            idle();
            #1;
            if (k == LATENCY) begin
                n_cmp++; if (mem_if.rsp_mem_push !== 1'b1) begin n_bad++; $display("FAIL st_ld_push: got %b expected 1", mem_if.rsp_mem_push); end
                n_cmp++; if (mem_if.rsp_mem_tag !== 3'd1) begin n_bad++; $display("FAIL st_ld_tag: got %0d expected 1", mem_if.rsp_mem_tag); end
                n_cmp++; if (mem_if.rsp_mem_q !== 64'hDEAD) begin n_bad++; $display("FAIL st_ld_data: got %h expected dead", mem_if.rsp_mem_q); end
                $display("rsp tag=%0d q=%h", mem_if.rsp_mem_tag, mem_if.rsp_mem_q);
            end else begin
                n_cmp++; if (mem_if.rsp_mem_push !== 1'b0) begin n_bad++; $display("FAIL st_ld_extra_push k=%0d: got %b expected 0", k, mem_if.rsp_mem_push); end
            end
        end
    endtask

    task automatic test_conflict();
        logic seen_push;
        seen_push = 1'b0;
        @(negedge clk);
        idle();
        mem_if.req_mem_ld       = 1'b1;
        mem_if.req_mem_st       = 1'b1;
        mem_if.req_mem_addr     = 48'h48;       // word 9
        mem_if.req_mem_d_or_tag = 64'hAB;
        host_addr               = 10'd9;
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (conflict !== 1'b1) begin n_bad++; $display("FAIL conflict_flag: got %b expected 1", conflict); end
        n_cmp++; if (host_q !== 64'hAB) begin n_bad++; $display("FAIL conflict_word9: got %h expected ab", host_q); end
        for (int k = 0; k < 6; k++) begin
            if (mem_if.rsp_mem_push) seen_push = 1'b1;
            @(negedge clk);
            #1;
        end
        n_cmp++; if (seen_push !== 1'b0) begin n_bad++; $display("FAIL conflict_no_rsp: got push=%b expected 0", seen_push); end
    endtask

    task automatic test_burst_overflow();
        logic seen_push;
        seen_push = 1'b0;
        mem_if.rsp_mem_stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive_load(100 + i, i % 8);
            #1;
            if (mem_if.rsp_mem_push) seen_push = 1'b1;
            n_cmp++; if (mem_if.req_mem_stall !== (i >= 13)) begin n_bad++; $display("FAIL burst_stall i=%0d: got %b expected %b", i, mem_if.req_mem_stall, (i >= 13)); end
            if (i == 19) begin
                n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL burst_overflow_early: got %b expected 0", overflow); end
            end
        end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL burst_overflow_set: got %b expected 1", overflow); end
        for (int k = 0; k < 4; k++) begin
            if (mem_if.rsp_mem_push) seen_push = 1'b1;
            @(negedge clk);
            #1;
        end
        n_cmp++; if (seen_push !== 1'b0) begin n_bad++; $display("FAIL burst_push_while_stalled: got %b expected 0", seen_push); end
        @(negedge clk);
        mem_if.rsp_mem_stall = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_cmp++; if (mem_if.rsp_mem_push !== 1'b1) begin n_bad++; $display("FAIL burst_rsp_push k=%0d: got %b expected 1", k, mem_if.rsp_mem_push); end
            n_cmp++; if (mem_if.rsp_mem_tag !== 3'(k % 8)) begin n_bad++; $display("FAIL burst_rsp_tag k=%0d: got %0d expected %0d", k, mem_if.rsp_mem_tag, k % 8); end
            n_cmp++; if (mem_if.rsp_mem_q !== dval(k)) begin n_bad++; $display("FAIL burst_rsp_data k=%0d: got %h expected %h", k, mem_if.rsp_mem_q, dval(k)); end
            if (k == 5) begin
                n_cmp++; if (mem_if.req_mem_stall !== 1'b1) begin n_bad++; $display("FAIL burst_stall_hold: got %b expected 1", mem_if.req_mem_stall); end
            end
            if (k == 6) begin
                n_cmp++; if (mem_if.req_mem_stall !== 1'b0) begin n_bad++; $display("FAIL burst_stall_clear: got %b expected 0", mem_if.req_mem_stall); end
            end
            $display("rsp %0d tag=%0d q=%h", k, mem_if.rsp_mem_tag, mem_if.rsp_mem_q);
        end
        @(negedge clk);
        #1;
        n_cmp++; if (mem_if.rsp_mem_push !== 1'b0) begin n_bad++; $display("FAIL burst_drained: got %b expected 0", mem_if.rsp_mem_push); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL burst_overflow_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_back_to_back_throttled();
        int  first;
        int  n_ld;
        logic seen_push;
        first = -1;
        n_ld = 0;
        seen_push = 1'b0;
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL thr_overflow_cleared: got %b expected 0", overflow); end
        n_cmp++; if (conflict !== 1'b0) begin n_bad++; $display("FAIL thr_conflict_cleared: got %b expected 0", conflict); end
        mem_if.rsp_mem_stall = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_if.req_mem_stall && first < 0) first = i;
            if (first >= 0 && i >= first + 2) begin
                idle();
                break;
            end
            drive_load(100 + n_ld, n_ld % 8);
            n_ld++;
        end
        n_cmp++; if (first !== 13) begin n_bad++; $display("FAIL thr_stall_cycle: got %0d expected 13", first); end
        n_cmp++; if (n_ld !== 15) begin n_bad++; $display("FAIL thr_load_count: got %0d expected 15", n_ld); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            idle();
            #1;
            if (mem_if.rsp_mem_push) seen_push = 1'b1;
        end
        n_cmp++; if (seen_push !== 1'b0) begin n_bad++; $display("FAIL thr_push_while_stalled: got %b expected 0", seen_push); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL thr_no_overflow: got %b expected 0", overflow); end
        @(negedge clk);
        mem_if.rsp_mem_stall = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_cmp++; if (mem_if.rsp_mem_push !== 1'b1) begin n_bad++; $display("FAIL thr_rsp_push k=%0d: got %b expected 1", k, mem_if.rsp_mem_push); end
            n_cmp++; if (mem_if.rsp_mem_tag !== 3'(k % 8)) begin n_bad++; $display("FAIL thr_rsp_tag k=%0d: got %0d expected %0d", k, mem_if.rsp_mem_tag, k % 8); end
            n_cmp++; if (mem_if.rsp_mem_q !== dval(k)) begin n_bad++; $display("FAIL thr_rsp_data k=%0d: got %h expected %h", k, mem_if.rsp_mem_q, dval(k)); end
            $display("rsp %0d tag=%0d q=%h", k, mem_if.rsp_mem_tag, mem_if.rsp_mem_q);
        end
        @(negedge clk);
        #1;
        n_cmp++; if (mem_if.rsp_mem_push !== 1'b0) begin n_bad++; $display("FAIL thr_drained: got %b expected 0", mem_if.rsp_mem_push); end
    endtask

    task automatic test_reset_inflight();
        logic seen_push;
        seen_push = 1'b0;
        mem_if.rsp_mem_stall = 1'b0;
        @(negedge clk);
        idle();
        mem_if.req_mem_ld       = 1'b1;
        mem_if.req_mem_st       = 1'b1;
        mem_if.req_mem_addr     = 48'h48;
        mem_if.req_mem_d_or_tag = 64'hAB;
        host_addr               = 10'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_load(100 + i, i);
        end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (conflict !== 1'b1) begin n_bad++; $display("FAIL rst_pre_conflict: got %b expected 1", conflict); end
        n_cmp++; if (host_q !== 64'hAB) begin n_bad++; $display("FAIL rst_pre_host_q: got %h expected ab", host_q); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (conflict !== 1'b0) begin n_bad++; $display("FAIL rst_async_conflict: got %b expected 0", conflict); end
        n_cmp++; if (host_q !== 64'd0) begin n_bad++; $display("FAIL rst_async_host_q: got %h expected 0", host_q); end
        n_cmp++; if (mem_if.rsp_mem_push !== 1'b0) begin n_bad++; $display("FAIL rst_async_push: got %b expected 0", mem_if.rsp_mem_push); end
        n_cmp++; if (mem_if.req_mem_stall !== 1'b0) begin n_bad++; $display("FAIL rst_async_stall: got %b expected 0", mem_if.req_mem_stall); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        host_addr = 10'd100;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (mem_if.rsp_mem_push) seen_push = 1'b1;
        end
        n_cmp++; if (seen_push !== 1'b0) begin n_bad++; $display("FAIL rst_stale_push: got %b expected 0", seen_push); end
        n_cmp++; if (host_q !== dval(0)) begin n_bad++; $display("FAIL rst_sram_kept100: got %h expected %h", host_q, dval(0)); end
        host_addr = 10'd9;
        @(negedge clk);
        drive_load(101, 5);
        #1;
        n_cmp++; if (host_q !== 64'hAB) begin n_bad++; $display("FAIL rst_sram_kept9: got %h expected ab", host_q); end
        for (int k = 1; k <= LATENCY; k++) begin
            @(negedge clk);
            idle();
        end
        #1;
        n_cmp++; if (mem_if.rsp_mem_push !== 1'b1) begin n_bad++; $display("FAIL rst_new_push: got %b expected 1", mem_if.rsp_mem_push); end
        n_cmp++; if (mem_if.rsp_mem_tag !== 3'd5) begin n_bad++; $display("FAIL rst_new_tag: got %0d expected 5", mem_if.rsp_mem_tag); end
        n_cmp++; if (mem_if.rsp_mem_q !== dval(1)) begin n_bad++; $display("FAIL rst_new_data: got %h expected %h", mem_if.rsp_mem_q, dval(1)); end
        $display("rsp tag=%0d q=%h", mem_if.rsp_mem_tag, mem_if.rsp_mem_q);
    endtask

    initial begin
        test_reset();
        test_host_preload();
        test_store_load();
        test_conflict();
        preload_words();
        test_burst_overflow();
        test_back_to_back_throttled();
        test_reset_inflight();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
